// File: rtl/oracle_event_buffer.sv
// Multi-channel pipeline trace buffer: timestamps up to NUM_CH events per cycle,
// queues them in order in a shared FIFO and drains one per cycle over valid/ready.
module oracle_event_buffer #(
    parameter int NUM_CH = 5,
    parameter int DEPTH  = 16,
    parameter int ID_W   = 32,
    parameter int DATA_W = 64,
    parameter int TS_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic                           clr_i,
    input  logic [NUM_CH-1:0]              ch_valid_i,
    input  logic [NUM_CH*ID_W-1:0]         ch_id_i,
    input  logic [NUM_CH*DATA_W-1:0]       ch_pc_i,
    input  logic [NUM_CH*DATA_W-1:0]       ch_a_i,
    input  logic [NUM_CH*DATA_W-1:0]       ch_b_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [$clog2(NUM_CH)-1:0]      out_kind_o,
    output logic [ID_W-1:0]                out_id_o,
    output logic [DATA_W-1:0]              out_pc_o,
    output logic [DATA_W-1:0]              out_a_o,
    output logic [DATA_W-1:0]              out_b_o,
    output logic [TS_W-1:0]                out_ts_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic [CNT_W-1:0]               drop_cnt_o,
    output logic                           overflow_o
);

    localparam int KIND_W = $clog2(NUM_CH);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH+1);
    localparam int N_W    = $clog2(NUM_CH+1);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [N_W-1:0]   inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic [KIND_W-1:0] mem_kind [DEPTH];
    logic [ID_W-1:0]   mem_id   [DEPTH];
    logic [DATA_W-1:0] mem_pc   [DEPTH];
    logic [DATA_W-1:0] mem_a    [DEPTH];
    logic [DATA_W-1:0] mem_b    [DEPTH];
    logic [TS_W-1:0]   mem_ts   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  count_q;
    logic [TS_W-1:0]   ts_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic              overflow_q;

    logic [N_W-1:0]    n_req;
    logic [PTR_W-1:0]  slot [NUM_CH];
    logic [OCC_W-1:0]  n_ext;
    logic [OCC_W-1:0]  free_slots;
    logic [OCC_W-1:0]  push_n;
    logic [OCC_W-1:0]  pop_n;
    logic              accept;
    logic              drop;
    logic              pop;

    // Lower-index channels take lower slots: each slot is wr_ptr plus the
    // number of valid channels below it.
    always_comb begin
        n_req = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            slot[c] = wr_ptr_q + PTR_W'(n_req);
            if (en_i && ch_valid_i[c]) begin
                n_req = n_req + N_W'(1);
            end
        end
    end

    // Free space is judged before this cycle's pop, so a slot being drained
    // right now never takes a new event.
    always_comb begin
        n_ext      = OCC_W'(n_req);
        free_slots = OCC_W'(DEPTH) - count_q;
        accept     = (n_ext <= free_slots);
        drop       = !accept;
        pop        = (count_q != '0) && out_ready_i;
        push_n     = accept ? n_ext : '0;
        pop_n      = {{(OCC_W-1){1'b0}}, pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q    <= ts_q + TS_W'(1);
            count_q <= count_q + push_n - pop_n;
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(n_req);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (clr_i) begin
                drop_cnt_q <= '0;
                overflow_q <= 1'b0;
            end else if (drop) begin
                drop_cnt_q <= sat_add(drop_cnt_q, n_req);
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rst_i && accept && en_i && ch_valid_i[c]) begin
                mem_kind[slot[c]] <= KIND_W'(c);
                mem_id[slot[c]]   <= ch_id_i[c*ID_W +: ID_W];
                mem_pc[slot[c]]   <= ch_pc_i[c*DATA_W +: DATA_W];
                mem_a[slot[c]]    <= ch_a_i[c*DATA_W +: DATA_W];
                mem_b[slot[c]]    <= ch_b_i[c*DATA_W +: DATA_W];
                mem_ts[slot[c]]   <= ts_q;
            end
        end
    end

    always_comb begin
        out_valid_o = (count_q != '0);
        out_kind_o  = out_valid_o ? mem_kind[rd_ptr_q] : '0;
        out_id_o    = out_valid_o ? mem_id[rd_ptr_q]   : '0;
        out_pc_o    = out_valid_o ? mem_pc[rd_ptr_q]   : '0;
        out_a_o     = out_valid_o ? mem_a[rd_ptr_q]    : '0;
        out_b_o     = out_valid_o ? mem_b[rd_ptr_q]    : '0;
        out_ts_o    = out_valid_o ? mem_ts[rd_ptr_q]   : '0;
    end

    assign count_o    = count_q;
    assign drop_cnt_o = drop_cnt_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_oracle_event_buffer.sv
// Directed bench for oracle_event_buffer: capture, ordering, overflow drops,
// saturation, clear, enable and mid-run reset.
module tb_oracle_event_buffer;

    localparam int NUM_CH = 5;
    localparam int DEPTH  = 16;
    localparam int ID_W   = 32;
    localparam int DATA_W = 64;
    localparam int TS_W   = 32;
    localparam int CNT_W  = 16;

    logic                       clk = 1'b0;
    logic                       rst_i = 1'b0;
    logic                       en_i = 1'b1;
    logic                       clr_i = 1'b0;
    logic [NUM_CH-1:0]          ch_valid_i = '0;
    logic [NUM_CH*ID_W-1:0]     ch_id_i = '0;
    logic [NUM_CH*DATA_W-1:0]   ch_pc_i = '0;
    logic [NUM_CH*DATA_W-1:0]   ch_a_i = '0;
    logic [NUM_CH*DATA_W-1:0]   ch_b_i = '0;
    logic                       out_valid_o;
    logic                       out_ready_i = 1'b0;
    logic [2:0]                 out_kind_o;
    logic [ID_W-1:0]            out_id_o;
    logic [DATA_W-1:0]          out_pc_o;
    logic [DATA_W-1:0]          out_a_o;
    logic [DATA_W-1:0]          out_b_o;
    logic [TS_W-1:0]            out_ts_o;
    logic [4:0]                 count_o;
    logic [CNT_W-1:0]           drop_cnt_o;
    logic                       overflow_o;

    int total = 0;
    int bad = 0;
    int ts_m = 0;
    int exp_q[$];

    oracle_event_buffer #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ID_W(ID_W),
        .DATA_W(DATA_W), .TS_W(TS_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .clr_i(clr_i),
        .ch_valid_i(ch_valid_i), .ch_id_i(ch_id_i), .ch_pc_i(ch_pc_i),
        .ch_a_i(ch_a_i), .ch_b_i(ch_b_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_kind_o(out_kind_o), .out_id_o(out_id_o), .out_pc_o(out_pc_o),
        .out_a_o(out_a_o), .out_b_o(out_b_o), .out_ts_o(out_ts_o),
        .count_o(count_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        if (rst_i) ts_m = 0;
        else ts_m = ts_m + 1;
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic set_ch(input int c, input int id, input logic [63:0] pc,
                          input logic [63:0] a, input logic [63:0] b);
        ch_valid_i[c] = 1'b1;
        ch_id_i[c*ID_W +: ID_W] = id;
        ch_pc_i[c*DATA_W +: DATA_W] = pc;
        ch_a_i[c*DATA_W +: DATA_W] = a;
        ch_b_i[c*DATA_W +: DATA_W] = b;
    endtask

    // id = base + 10*batch + channel, so kind is recoverable as id % 10
    task automatic push_batch(input int base, input int batch);
        for (int c = 0; c < NUM_CH; c++) begin
            set_ch(c, base + 10*batch + c, 64'h1000 + 64'(c), 64'(c), 64'(batch));
        end
    endtask

    task automatic test_reset();
        ch_valid_i = '1;
        do_reset();
        ch_valid_i = '0;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d want=0", out_valid_o); end
        total++; if (count_o !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_o); end
        total++; if (drop_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0d want=0", overflow_o); end
        total++; if (out_id_o !== 32'd0 || out_ts_o !== 32'd0) begin bad++; $display("FAIL reset_data got id=%0d ts=%0d want 0", out_id_o, out_ts_o); end
    endtask

    task automatic test_single();
        do_reset();
        repeat (5) step();
        set_ch(1, 7, 64'h80000000, 64'h11, 64'h0);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_same_cycle got=%0d want=0", out_valid_o); end
        step();
        ch_valid_i = '0;
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%0d want=1", out_valid_o); end
        total++; if (out_kind_o !== 3'd1) begin bad++; $display("FAIL single_kind got=%0d want=1", out_kind_o); end
        total++; if (out_id_o !== 32'd7) begin bad++; $display("FAIL single_id got=%0d want=7", out_id_o); end
        total++; if (out_pc_o !== 64'h80000000) begin bad++; $display("FAIL single_pc got=%h want=80000000", out_pc_o); end
        total++; if (out_a_o !== 64'h11 || out_b_o !== 64'h0) begin bad++; $display("FAIL single_ab got a=%h b=%h want 11 0", out_a_o, out_b_o); end
        total++; if (out_ts_o !== 32'd5) begin bad++; $display("FAIL single_ts got=%0d want=5", out_ts_o); end
        total++; if (count_o !== 5'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count_o); end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        total++; if (out_valid_o !== 1'b0 || count_o !== 5'd0) begin bad++; $display("FAIL single_pop got v=%0d cnt=%0d want 0 0", out_valid_o, count_o); end
    endtask

    task automatic test_all_channels();
        int cap_ts;
        do_reset();
        push_batch(100, 0);
        cap_ts = ts_m;
        out_ready_i = 1'b1;
        step();
        ch_valid_i = '0;
        total++; if (count_o !== 5'd5) begin bad++; $display("FAIL all5_count got=%0d want=5", count_o); end
        for (int k = 0; k < NUM_CH; k++) begin
            total++;
            if (out_valid_o !== 1'b1 || out_kind_o !== 3'(k) || out_id_o !== 32'(100 + k) || out_ts_o !== 32'(cap_ts)) begin
                bad++; $display("FAIL all5_out%0d got v=%0d kind=%0d id=%0d ts=%0d want 1 %0d %0d %0d",
                                k, out_valid_o, out_kind_o, out_id_o, out_ts_o, k, 100 + k, cap_ts);
            end
            step();
        end
        out_ready_i = 1'b0;
        total++; if (count_o !== 5'd0) begin bad++; $display("FAIL all5_drained got=%0d want=0", count_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            push_batch(200, b);
            step();
            for (int c = 0; c < NUM_CH; c++) exp_q.push_back(200 + 10*b + c);
        end
        ch_valid_i = '0;
        total++; if (count_o !== 5'd15) begin bad++; $display("FAIL ovf_fill got=%0d want=15", count_o); end
        total++; if (out_id_o !== 32'd200) begin bad++; $display("FAIL ovf_hold_head got=%0d want=200", out_id_o); end
        set_ch(0, 290, 0, 0, 0);
        set_ch(2, 292, 0, 0, 0);
        step();
        ch_valid_i = '0;
        total++; if (count_o !== 5'd15 || drop_cnt_o !== 16'd2 || overflow_o !== 1'b1) begin
            bad++; $display("FAIL ovf_drop2 got cnt=%0d drop=%0d ovf=%0d want 15 2 1", count_o, drop_cnt_o, overflow_o); end
        set_ch(3, 233, 0, 0, 0);
        step();
        ch_valid_i = '0;
        exp_q.push_back(233);
        total++; if (count_o !== 5'd16 || drop_cnt_o !== 16'd2) begin
            bad++; $display("FAIL ovf_last_slot got cnt=%0d drop=%0d want 16 2", count_o, drop_cnt_o); end
    endtask

    task automatic test_full_pop_push();
        out_ready_i = 1'b1;
        set_ch(4, 244, 0, 0, 0);
        step();
        out_ready_i = 1'b0;
        ch_valid_i = '0;
        void'(exp_q.pop_front());
        total++; if (count_o !== 5'd15 || drop_cnt_o !== 16'd3) begin
            bad++; $display("FAIL full_pop got cnt=%0d drop=%0d want 15 3", count_o, drop_cnt_o); end
        total++; if (out_id_o !== 32'd201) begin bad++; $display("FAIL full_pop_head got=%0d want=201", out_id_o); end
    endtask

    task automatic test_clear();
        set_ch(0, 250, 0, 0, 0);
        set_ch(1, 251, 0, 0, 0);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        ch_valid_i = '0;
        total++; if (drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin
            bad++; $display("FAIL clr_wins got drop=%0d ovf=%0d want 0 0", drop_cnt_o, overflow_o); end
        total++; if (count_o !== 5'd15) begin bad++; $display("FAIL clr_fifo got=%0d want=15", count_o); end
        out_ready_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            total++;
            if (exp_q.size() == 0 || out_valid_o !== 1'b1 || out_id_o !== 32'(exp_q[0]) || out_kind_o !== 3'(exp_q[0] % 10)) begin
                bad++; $display("FAIL clr_drain%0d got v=%0d id=%0d kind=%0d want id=%0d",
                                i, out_valid_o, out_id_o, out_kind_o, (exp_q.size() != 0) ? exp_q[0] : -1);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            step();
        end
        out_ready_i = 1'b0;
        total++; if (count_o !== 5'd0 || out_valid_o !== 1'b0) begin
            bad++; $display("FAIL clr_empty got cnt=%0d v=%0d want 0 0", count_o, out_valid_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            push_batch(300, b);
            step();
        end
        ch_valid_i = '0;
        set_ch(0, 399, 0, 0, 0);
        step();
        push_batch(400, 0);
        repeat (13106) step();
        total++; if (drop_cnt_o !== 16'd65530) begin bad++; $display("FAIL sat_pre got=%0d want=65530", drop_cnt_o); end
        repeat (4) step();
        ch_valid_i = '0;
        total++; if (drop_cnt_o !== 16'hFFFF || overflow_o !== 1'b1 || count_o !== 5'd16) begin
            bad++; $display("FAIL sat_hold got drop=%0d ovf=%0d cnt=%0d want 65535 1 16", drop_cnt_o, overflow_o, count_o); end
    endtask

    task automatic test_enable();
        do_reset();
        en_i = 1'b0;
        push_batch(500, 0);
        step();
        ch_valid_i = '0;
        en_i = 1'b1;
        total++; if (count_o !== 5'd0 || out_valid_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
            bad++; $display("FAIL en_off got cnt=%0d v=%0d drop=%0d want 0 0 0", count_o, out_valid_o, drop_cnt_o); end
    endtask

    task automatic test_random_wrap();
        int q_id[$];
        int q_k[$];
        int q_ts[$];
        int cnt_m;
        int drop_m;
        int next_id;
        int n;
        int cap_ts;
        logic [NUM_CH-1:0] v;
        logic rdy;
        logic do_pop;
        do_reset();
        cnt_m = 0; drop_m = 0; next_id = 1000;
        for (int cyc = 0; cyc < 90; cyc++) begin
            v = NUM_CH'($urandom) & NUM_CH'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            ch_valid_i = v;
            for (int c = 0; c < NUM_CH; c++) ch_id_i[c*ID_W +: ID_W] = 32'(next_id + c);
            out_ready_i = rdy;
            n = $countones(v);
            do_pop = (cnt_m > 0) && rdy;
            if (do_pop) begin
                total++;
                if (out_valid_o !== 1'b1 || out_id_o !== 32'(q_id[0]) || out_kind_o !== 3'(q_k[0]) || out_ts_o !== 32'(q_ts[0])) begin
                    bad++; $display("FAIL rnd_head cyc=%0d got v=%0d id=%0d kind=%0d ts=%0d want id=%0d kind=%0d ts=%0d",
                                    cyc, out_valid_o, out_id_o, out_kind_o, out_ts_o, q_id[0], q_k[0], q_ts[0]);
                end
            end
            cap_ts = ts_m;
            step();
            if (n <= DEPTH - cnt_m) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (v[c]) begin q_id.push_back(next_id + c); q_k.push_back(c); q_ts.push_back(cap_ts); end
                end
                cnt_m += n;
            end else begin
                drop_m = (drop_m + n > 65535) ? 65535 : drop_m + n;
            end
            if (do_pop) begin
                void'(q_id.pop_front()); void'(q_k.pop_front()); void'(q_ts.pop_front());
                cnt_m--;
            end
            next_id += 5;
            total++;
            if (count_o !== 5'(cnt_m) || drop_cnt_o !== 16'(drop_m)) begin
                bad++; $display("FAIL rnd_state cyc=%0d got cnt=%0d drop=%0d want %0d %0d", cyc, count_o, drop_cnt_o, cnt_m, drop_m);
            end
        end
        ch_valid_i = '0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 20 && q_id.size() != 0; i++) begin
            total++;
            if (out_valid_o !== 1'b1 || out_id_o !== 32'(q_id[0]) || out_kind_o !== 3'(q_k[0])) begin
                bad++; $display("FAIL rnd_drain got v=%0d id=%0d kind=%0d want id=%0d kind=%0d", out_valid_o, out_id_o, out_kind_o, q_id[0], q_k[0]);
            end
            void'(q_id.pop_front()); void'(q_k.pop_front()); void'(q_ts.pop_front());
            step();
        end
        out_ready_i = 1'b0;
        total++; if (count_o !== 5'd0) begin bad++; $display("FAIL rnd_final got cnt=%0d want 0", count_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            push_batch(600, b);
            step();
        end
        ch_valid_i = '0;
        set_ch(0, 690, 0, 0, 0);
        set_ch(1, 691, 0, 0, 0);
        step();
        ch_valid_i = '0;
        out_ready_i = 1'b1;
        repeat (5) step();
        out_ready_i = 1'b0;
        total++; if (count_o !== 5'd10 || overflow_o !== 1'b1 || drop_cnt_o !== 16'd2) begin
            bad++; $display("FAIL mid_pre got cnt=%0d ovf=%0d drop=%0d want 10 1 2", count_o, overflow_o, drop_cnt_o); end
        set_ch(4, 699, 0, 0, 0);
        do_reset();
        ch_valid_i = '0;
        total++; if (out_valid_o !== 1'b0 || count_o !== 5'd0 || drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin
            bad++; $display("FAIL mid_reset got v=%0d cnt=%0d drop=%0d ovf=%0d want 0 0 0 0", out_valid_o, count_o, drop_cnt_o, overflow_o); end
        set_ch(2, 77, 64'h4, 64'h5, 64'h6);
        step();
        ch_valid_i = '0;
        total++; if (out_valid_o !== 1'b1 || out_ts_o !== 32'd0 || out_id_o !== 32'd77 || out_kind_o !== 3'd2) begin
            bad++; $display("FAIL mid_ts got v=%0d ts=%0d id=%0d kind=%0d want 1 0 77 2", out_valid_o, out_ts_o, out_id_o, out_kind_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_overflow();
        test_full_pop_push();
        test_clear();
        test_enable();
        test_random_wrap();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
